// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
//
// Purpose: RV32I load/store funct3 encodings and the controller state type.
// Ports:   none (package).

package lsu_pkg;

    // RV32I funct3 encodings for loads and stores.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // IDLE   : accepts requests; loads, SW and faults finish here.
    // RMW_WR : second cycle of SB/SH, writes the merged word.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_unit.sv
// rtl/lsu_lane_unit.sv - byte/halfword lane extract and merge
//
// Purpose: combinational lane logic for the load/store controller.
//   Load path : picks the addressed byte/halfword from a memory word and
//               sign- or zero-extends it according to funct3.
//   Store path: inserts store data into the addressed lane of the old word.
// Ports:
//   i_word    in  32  word read from memory (load source / merge base)
//   i_st_data in  32  store data (rs2)
//   i_addr_lo in  2   byte offset within the word
//   i_funct3  in  3   RV32I access size/sign
//   o_ld_data out 32  extended load result
//   o_st_word out 32  word with store data merged in

module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte lane by addr[1:0], halfword lane by addr[1].
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    // Load extend.
    always_comb begin
        o_ld_data = i_word;
        case (i_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h000000, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0000, w_half};
            default: o_ld_data = i_word;
        endcase
    end

    // Store merge: only the addressed lane changes, the rest of the old word
    // is preserved. A full-word store simply passes the new data through.
    always_comb begin
        o_st_word = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0:    o_st_word[7:0]   = i_st_data[7:0];
                    2'd1:    o_st_word[15:8]  = i_st_data[7:0];
                    2'd2:    o_st_word[23:16] = i_st_data[7:0];
                    default: o_st_word[31:24] = i_st_data[7:0];
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_st_word[31:16] = i_st_data[15:0];
                end else begin
                    o_st_word[15:0]  = i_st_data[15:0];
                end
            end
            default: o_st_word = i_st_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store controller for a word-only memory
//
// Purpose: sits between the MEM pipeline stage and a word-addressed data
//   memory (async read, write on negedge). Loads and SW finish in one cycle;
//   SB/SH run as a two-cycle read-modify-write with a one-cycle stall.
//   Misaligned, out-of-range and illegal-funct3 requests are rejected.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req_valid/req_we   request present / store(1) or load(0)
//   req_funct3         RV32I size/sign encoding
//   req_addr/req_wdata byte address / store data
//   stall              hold the MEM stage (request must stay stable)
//   rdata              extended load result
//   fault/fault_addr   current request rejected / last faulting address
//   mem_we/mem_addr/mem_wdata/mem_rdata  memory interface (word-aligned)

module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int FUNCT3_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [FUNCT3_W-1:0] req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                stall,
    output logic [31:0]         rdata,
    output logic                fault,
    output logic [31:0]         fault_addr,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic [31:0] r_wbuf;
    logic [31:0] r_waddr;
    logic [31:0] r_fault_addr;

    logic [2:0]  w_f3;
    logic [31:0] w_aligned;
    logic        w_active;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_fault;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_word;
    logic        w_fault_capture;
    logic        w_rmw_capture;

    assign w_f3      = req_funct3[2:0];
    assign w_aligned = {req_addr[31:2], 2'b00};

    // While reset is held the controller behaves as if no request is present,
    // so a pending write cannot reach memory during reset.
    assign w_active = req_valid & ~rst;

    // funct3[1:0] gives the size (0 byte, 1 half, 2 word) for both signed and
    // unsigned loads; stores only have the signed encodings.
    assign w_illegal = req_we ? (w_f3 > F3_W)
                              : ((w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7));
    assign w_misalign = ((w_f3[1:0] == 2'b01) && req_addr[0]) ||
                        ((w_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = (req_addr >= MEM_LIMIT);
    assign w_fault        = w_illegal | w_misalign | w_out_of_range;

    lsu_lane_unit u_lane (
        .i_word    (mem_rdata),
        .i_st_data (req_wdata),
        .i_addr_lo (req_addr[1:0]),
        .i_funct3  (w_f3),
        .o_ld_data (w_ld_data),
        .o_st_word (w_st_word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs.
    always_comb begin
        w_state_next    = r_state;
        stall           = 1'b0;
        rdata           = 32'h0;
        fault           = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;
        w_fault_capture = 1'b0;
        w_rmw_capture   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_active) begin
                    if (w_fault) begin
                        fault           = 1'b1;
                        w_fault_capture = 1'b1;
                    end else if (!req_we) begin
                        mem_addr = w_aligned;
                        rdata    = w_ld_data;
                    end else if (w_f3 == F3_W) begin
                        mem_we    = 1'b1;
                        mem_addr  = w_aligned;
                        mem_wdata = req_wdata;
                    end else begin
                        // SB/SH read phase: memory returns the old word this
                        // cycle, merged word is captured at the posedge.
                        mem_addr      = w_aligned;
                        stall         = 1'b1;
                        w_rmw_capture = 1'b1;
                        w_state_next  = RMW_WR;
                    end
                end
            end

            RMW_WR: begin
                // Request inputs are ignored; the merged word goes out.
                mem_we       = 1'b1;
                mem_addr     = r_waddr;
                mem_wdata    = r_wbuf;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Data registers: RMW buffer/address and last faulting address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbuf       <= 32'h0;
            r_waddr      <= 32'h0;
            r_fault_addr <= 32'h0;
        end else begin
            if (w_rmw_capture) begin
                r_wbuf  <= w_st_word;
                r_waddr <= w_aligned;
            end
            if (w_fault_capture) begin
                r_fault_addr <= req_addr;
            end
        end
    end

    assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl

module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] fault_addr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_checks;
    int n_fail;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    lsu_mem_ctrl #(.MEM_BYTES(1024), .FUNCT3_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .fault      (fault),
        .fault_addr (fault_addr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: async read, undefined while writing, write on negedge.
    assign mem_rdata = mem_we ? 32'hxxxxxxxx : mem[mem_addr[9:2]];
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic push(input string tag, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_exp.push_back(exp);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        tag = q_tag.pop_front();
        exp = q_exp.pop_front();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request just after a posedge, leave time for async logic.
    task automatic step(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #3;
    endtask

    // Wait (bounded) for the RMW write cycle, then pop the queued checks.
    task automatic rmw_wait(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #4;
            if (mem_we === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed=no_write expected=write_within_4_cycles", tag);
        end
        chk({31'h0, mem_we});
        chk(mem_addr);
        chk(mem_wdata);
        chk({31'h0, stall});
        chk({31'h0, fault});
    endtask

    task automatic push_rmw_wr(input string tag, input logic [31:0] addr, input logic [31:0] word);
        push({tag, "_c1_we"},    32'h1);
        push({tag, "_c1_addr"},  addr);
        push({tag, "_c1_wdata"}, word);
        push({tag, "_c1_stall"}, 32'h0);
        push({tag, "_c1_fault"}, 32'h0);
    endtask

    task automatic check_fault(input string tag);
        push({tag, "_fault"}, 32'h1);
        push({tag, "_we"},    32'h0);
        push({tag, "_stall"}, 32'h0);
        push({tag, "_rdata"}, 32'h0);
        chk({31'h0, fault});
        chk({31'h0, mem_we});
        chk({31'h0, stall});
        chk(rdata);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state.
        #4;
        push("rst_stall", 32'h0);      chk({31'h0, stall});
        push("rst_fault", 32'h0);      chk({31'h0, fault});
        push("rst_we", 32'h0);         chk({31'h0, mem_we});
        push("rst_rdata", 32'h0);      chk(rdata);
        push("rst_addr", 32'h0);       chk(mem_addr);
        push("rst_wdata", 32'h0);      chk(mem_wdata);
        push("rst_fault_addr", 32'h0); chk(fault_addr);
        @(posedge clk);
        #1 rst = 1'b0;

        // SW then byte/half loads.
        step(1, 1, 3'd2, 32'h10, 32'h8899AABB);
        push("sw_we", 32'h1);            chk({31'h0, mem_we});
        push("sw_stall", 32'h0);         chk({31'h0, stall});
        push("sw_addr", 32'h10);         chk(mem_addr);
        push("sw_wdata", 32'h8899AABB);  chk(mem_wdata);

        step(1, 0, 3'd0, 32'h13, 32'h0);
        push("lb_13", 32'hFFFFFF88);     chk(rdata);
        push("lb_13_addr", 32'h10);      chk(mem_addr);
        step(1, 0, 3'd4, 32'h13, 32'h0);
        push("lbu_13", 32'h00000088);    chk(rdata);
        step(1, 0, 3'd1, 32'h12, 32'h0);
        push("lh_12", 32'hFFFF8899);     chk(rdata);
        step(1, 0, 3'd2, 32'h10, 32'h0);
        push("lw_10", 32'h8899AABB);     chk(rdata);

        // SB read-modify-write.
        step(1, 1, 3'd0, 32'h11, 32'h123456CC);
        push("sb_c0_stall", 32'h1);      chk({31'h0, stall});
        push("sb_c0_we", 32'h0);         chk({31'h0, mem_we});
        push("sb_c0_addr", 32'h10);      chk(mem_addr);
        push_rmw_wr("sb", 32'h10, 32'h8899CCBB);
        rmw_wait("sb");
        step(1, 0, 3'd2, 32'h10, 32'h0);
        push("lw_after_sb", 32'h8899CCBB); chk(rdata);

        // SH read-modify-write.
        step(1, 1, 3'd1, 32'h12, 32'h0000BEEF);
        push("sh_c0_stall", 32'h1);      chk({31'h0, stall});
        push_rmw_wr("sh", 32'h10, 32'hBEEFCCBB);
        rmw_wait("sh");
        step(1, 0, 3'd5, 32'h12, 32'h0);
        push("lhu_12", 32'h0000BEEF);    chk(rdata);
        step(1, 0, 3'd1, 32'h10, 32'h0);
        push("lh_10", 32'hFFFFCCBB);     chk(rdata);

        // Faults.
        step(1, 0, 3'd2, 32'h12, 32'h0);
        check_fault("lw_mis");
        step(0, 0, 3'd0, 32'h0, 32'h0);
        push("fault_addr_12", 32'h12);   chk(fault_addr);
        push("idle_fault", 32'h0);       chk({31'h0, fault});
        step(1, 1, 3'd1, 32'h11, 32'hFFFFFFFF);
        check_fault("sh_mis");
        step(1, 1, 3'd2, 32'h400, 32'hDEADBEEF);
        check_fault("sw_oor");
        step(1, 0, 3'd3, 32'h10, 32'h0);
        check_fault("ld_f3_3");
        push("fault_addr_400", 32'h400); chk(fault_addr);
        step(1, 1, 3'd4, 32'h10, 32'h0);
        check_fault("st_f3_4");
        step(1, 0, 3'd0, 32'h400, 32'h0);
        check_fault("lb_oor");

        // Last in-range word is accepted.
        step(1, 0, 3'd2, 32'h3FC, 32'h0);
        push("lw_3fc_fault", 32'h0);     chk({31'h0, fault});
        push("lw_3fc_addr", 32'h3FC);    chk(mem_addr);

        // Memory untouched by the faulting stores.
        step(1, 0, 3'd2, 32'h10, 32'h0);
        push("lw_10_final", 32'hBEEFCCBB); chk(rdata);

        // Reset in the middle of a read-modify-write.
        step(1, 1, 3'd2, 32'h20, 32'h11223344);
        push("sw_20_we", 32'h1);         chk({31'h0, mem_we});
        step(1, 1, 3'd0, 32'h20, 32'h000000AA);
        push("sb20_c0_stall", 32'h1);    chk({31'h0, stall});
        @(posedge clk);
        #1;
        push("sb20_c1_we", 32'h1);       chk({31'h0, mem_we});
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        push("rst_mid_we", 32'h0);       chk({31'h0, mem_we});
        push("rst_mid_stall", 32'h0);    chk({31'h0, stall});
        push("rst_mid_fault_addr", 32'h0); chk(fault_addr);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, 3'd2, 32'h20, 32'h0);
        push("lw_20_after_rst", 32'h11223344); chk(rdata);
        push("lw_20_stall", 32'h0);      chk({31'h0, stall});

        step(0, 0, 3'd0, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
